// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings,
// board defaults, bounce direction type and the mode-advance rule.
package led_pkg;

    localparam int unsigned CLOCK_XTAL_DEFAULT = 27000000;
    localparam int unsigned LED_NUM_DEFAULT    = 6;

    localparam int unsigned MODE_W   = 3;
    localparam int unsigned MODE_NUM = 5;

    localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_BLINK  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_CHASE  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd3;
    localparam logic [MODE_W-1:0] MODE_COUNT  = 3'd4;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } bounce_dir_t;

    // Modes cycle OFF..COUNT; any out-of-range encoding returns to OFF.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
        if (m < MODE_COUNT)
            return m + 1'b1;
        else
            return MODE_OFF;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler for the pattern step rate: one tick every TICK_DIV unpaused
// cycles. pause freezes the count; clr restarts the step period.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6750000
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    input  logic clr,
    output logic tick
);

    localparam int unsigned          CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST) && !pause;

    // Count 0..TICK_DIV-1, wrapping on tick, holding while paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (!pause)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank controller: steps one of five display patterns at the prescaled
// rate, with mode selection by single-cycle pulse and a pause level.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int unsigned CLOCK_XTAL = CLOCK_XTAL_DEFAULT,
    parameter int unsigned LED_NUM    = LED_NUM_DEFAULT,
    parameter int unsigned TICK_DIV   = CLOCK_XTAL / 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_next,
    input  logic               pause,
    output logic [LED_NUM-1:0] leds,
    output logic [MODE_W-1:0]  mode,
    output logic               step_tick
);

    if (LED_NUM < 2 || LED_NUM > 16) begin : g_bad_led_num
        $error("LED_NUM must be in 2..16");
    end
    if (TICK_DIV < 2 || CLOCK_XTAL == 0) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2 and CLOCK_XTAL non-zero");
    end

    logic [MODE_W-1:0]  mode_q,    mode_n;
    logic [LED_NUM-1:0] pattern_q, pattern_n;
    bounce_dir_t        dir_q,     dir_n;
    logic               step_q,    step_n;
    logic               tick;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .pause (pause),
        .clr   (mode_next),
        .tick  (tick)
    );

    // State register for mode, pattern, bounce direction and step pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_BLINK;
            pattern_q <= '1;
            dir_q     <= DIR_UP;
            step_q    <= 1'b0;
        end else begin
            mode_q    <= mode_n;
            pattern_q <= pattern_n;
            dir_q     <= dir_n;
            step_q    <= step_n;
        end
    end

    // Mode change takes priority over a coincident tick, which is dropped.
    always_comb begin
        mode_n    = mode_q;
        pattern_n = pattern_q;
        dir_n     = dir_q;
        step_n    = 1'b0;
        if (mode_next) begin
            mode_n = next_mode(mode_q);
            dir_n  = DIR_UP;
            case (mode_n)
                MODE_BLINK:              pattern_n = '1;
                MODE_CHASE, MODE_BOUNCE: pattern_n = LED_NUM'(1);
                default:                 pattern_n = '0;
            endcase
        end else if (tick) begin
            step_n = 1'b1;
            case (mode_q)
                MODE_BLINK: pattern_n = ~pattern_q;
                MODE_CHASE: pattern_n = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
                MODE_BOUNCE: begin
                    // Direction flips as the lit LED lands on an end, so ends show once.
                    if (dir_q == DIR_UP) begin
                        pattern_n = pattern_q << 1;
                        if (pattern_q[LED_NUM-2])
                            dir_n = DIR_DOWN;
                    end else begin
                        pattern_n = pattern_q >> 1;
                        if (pattern_q[1])
                            dir_n = DIR_UP;
                    end
                end
                MODE_COUNT: pattern_n = pattern_q + 1'b1;
                default:    pattern_n = '0;
            endcase
        end
    end

    assign leds      = ~pattern_q;
    assign mode      = mode_q;
    assign step_tick = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer with TICK_DIV=4, LED_NUM=6.
module tb_led_pattern_sequencer;

    localparam int TD = 4;
    localparam int LN = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode_next;
    logic          pause;
    logic [LN-1:0] leds;
    logic [2:0]    mode;
    logic          step_tick;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode, ticks since mode load, cycles into step period.
    int m_mode;
    int m_idx;
    int m_phase;
    bit m_tick;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .CLOCK_XTAL (27000000),
        .LED_NUM    (LN),
        .TICK_DIV   (TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_next (mode_next),
        .pause     (pause),
        .leds      (leds),
        .mode      (mode),
        .step_tick (step_tick)
    );

    function automatic logic [LN-1:0] exp_pattern();
        int p;
        case (m_mode)
            1: return (m_idx % 2 == 0) ? '1 : '0;
            2: return LN'(1) << (m_idx % LN);
            3: begin
                p = m_idx % (2 * (LN - 1));
                if (p >= LN) p = 2 * (LN - 1) - p;
                return LN'(1) << p;
            end
            4: return LN'(m_idx % (1 << LN));
            default: return '0;
        endcase
    endfunction

    function automatic logic [LN-1:0] exp_leds();
        return ~exp_pattern();
    endfunction

    task automatic model_reset();
        m_mode  = 1;
        m_idx   = 0;
        m_phase = 0;
        m_tick  = 0;
    endtask

    // Drive inputs, take one clock edge, advance the model, sample 1 ns later.
    task automatic cycle(input bit mn, input bit pz);
        mode_next = mn;
        pause     = pz;
        @(posedge clk);
        if (mn) begin
            m_mode  = (m_mode + 1) % 5;
            m_idx   = 0;
            m_phase = 0;
            m_tick  = 0;
        end else if (pz) begin
            m_tick = 0;
        end else if (m_phase == TD - 1) begin
            m_phase = 0;
            m_idx++;
            m_tick = 1;
        end else begin
            m_phase++;
            m_tick = 0;
        end
        #1;
        mode_next = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_next = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (mode !== 3'd1) begin failures++; $display("FAIL reset_mode got=%0d exp=1", mode); end
        checks++; if (leds !== 6'b000000) begin failures++; $display("FAIL reset_leds got=%b exp=000000", leds); end
        checks++; if (step_tick !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step_tick); end
        for (int e = 1; e <= 8; e++) begin
            cycle(0, 0);
            checks++;
            if (step_tick !== ((e % 4) == 0)) begin failures++; $display("FAIL blink_step edge=%0d got=%b", e, step_tick); end
            if (e == 4) begin
                checks++; if (leds !== 6'b111111) begin failures++; $display("FAIL blink_tick1 got=%b exp=111111", leds); end
            end
            if (e == 8) begin
                checks++; if (leds !== 6'b000000) begin failures++; $display("FAIL blink_tick2 got=%b exp=000000", leds); end
            end
        end
    endtask

    task automatic test_chase();
        logic [LN-1:0] want;
        cycle(1, 0);
        checks++; if (mode !== 3'd2) begin failures++; $display("FAIL chase_mode got=%0d exp=2", mode); end
        checks++; if (leds !== 6'b111110) begin failures++; $display("FAIL chase_init got=%b exp=111110", leds); end
        for (int k = 1; k <= 6; k++) begin
            repeat (TD) cycle(0, 0);
            want = ~(LN'(1) << (k % LN));
            checks++;
            if (leds !== want || step_tick !== 1'b1) begin
                failures++; $display("FAIL chase_tick%0d got=%b/%b exp=%b/1", k, leds, step_tick, want);
            end
        end
    endtask

    task automatic test_count();
        logic [LN-1:0] want;
        cycle(1, 0);
        cycle(1, 0);
        checks++; if (mode !== 3'd4 || leds !== 6'b111111) begin
            failures++; $display("FAIL count_init got=%0d/%b exp=4/111111", mode, leds);
        end
        for (int k = 1; k <= 64; k++) begin
            repeat (TD) cycle(0, 0);
            want = ~LN'(k % 64);
            checks++;
            if (leds !== want) begin failures++; $display("FAIL count_tick%0d got=%b exp=%b", k, leds, want); end
        end
    endtask

    task automatic test_pause();
        logic [LN-1:0] held;
        int guard;
        guard = 0;
        while (m_phase != 2 && guard < 2 * TD) begin cycle(0, 0); guard++; end
        held = leds;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1);
            checks++;
            if (step_tick !== 1'b0 || leds !== held) begin
                failures++; $display("FAIL pause_hold i=%0d got=%b/%b exp=0/%b", i, step_tick, leds, held);
            end
        end
        cycle(0, 0);
        checks++; if (step_tick !== 1'b0) begin failures++; $display("FAIL pause_resume1 got=%b exp=0", step_tick); end
        cycle(0, 0);
        checks++; if (step_tick !== 1'b1 || leds !== exp_leds()) begin
            failures++; $display("FAIL pause_resume2 got=%b/%b exp=1/%b", step_tick, leds, exp_leds());
        end
        cycle(0, 1);
        cycle(1, 1);
        checks++; if (mode !== 3'd0 || leds !== 6'b111111) begin
            failures++; $display("FAIL pause_mode_next got=%0d/%b exp=0/111111", mode, leds);
        end
        repeat (6) cycle(0, 1);
        cycle(0, 0);
    endtask

    task automatic test_bounce();
        int bpos [10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};
        logic [LN-1:0] want;
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 0);
        checks++; if (mode !== 3'd3 || leds !== 6'b111110) begin
            failures++; $display("FAIL bounce_init got=%0d/%b exp=3/111110", mode, leds);
        end
        for (int k = 0; k < 10; k++) begin
            repeat (TD) cycle(0, 0);
            want = ~(LN'(1) << bpos[k]);
            checks++;
            if (leds !== want) begin failures++; $display("FAIL bounce_tick%0d got=%b exp=%b", k + 1, leds, want); end
        end
    endtask

    task automatic test_collision();
        int guard;
        guard = 0;
        while (m_phase != TD - 1 && guard < 2 * TD) begin cycle(0, 0); guard++; end
        cycle(1, 0);
        checks++; if (mode !== 3'd4 || step_tick !== 1'b0 || leds !== 6'b111111) begin
            failures++; $display("FAIL collide got=%0d/%b/%b exp=4/0/111111", mode, step_tick, leds);
        end
        for (int e = 1; e <= TD; e++) begin
            cycle(0, 0);
            checks++;
            if (step_tick !== (e == TD)) begin failures++; $display("FAIL collide_step edge=%0d got=%b", e, step_tick); end
        end
        checks++; if (leds !== 6'b111110) begin failures++; $display("FAIL collide_first got=%b exp=111110", leds); end
        cycle(1, 0);
        checks++; if (mode !== 3'd0) begin failures++; $display("FAIL wrap_off got=%0d exp=0", mode); end
        for (int e = 1; e <= 2 * TD; e++) begin
            cycle(0, 0);
            checks++;
            if (leds !== 6'b111111 || step_tick !== m_tick) begin
                failures++; $display("FAIL off_hold edge=%0d got=%b/%b exp=111111/%b", e, leds, step_tick, m_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0);
        cycle(1, 0);
        repeat (TD + 2) cycle(0, 0);
        checks++; if (mode !== 3'd2 || leds !== exp_leds()) begin
            failures++; $display("FAIL pre_reset got=%0d/%b exp=2/%b", mode, leds, exp_leds());
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (leds !== 6'b000000 || mode !== 3'd1 || step_tick !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%b/%0d/%b exp=000000/1/0", leds, mode, step_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        bit mn;
        bit pz;
        pz = 0;
        for (int i = 0; i < 800; i++) begin
            mn = ($urandom_range(15) == 0);
            if ($urandom_range(9) == 0) pz = ~pz;
            cycle(mn, pz);
            checks++;
            if (mode !== 3'(m_mode) || leds !== exp_leds() || step_tick !== m_tick) begin
                failures++;
                $display("FAIL random i=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                         i, mode, leds, step_tick, m_mode, exp_leds(), m_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_chase();
        test_count();
        test_pause();
        test_bounce();
        test_collision();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
